// File: rtl/coin_pkg.sv
// Shared constants for the coin acceptor: downstream coin codes, coin values
// and the scheduler state encoding.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    localparam logic [7:0] VAL_1 = 8'd1;
    localparam logic [7:0] VAL_2 = 8'd2;
    localparam logic [7:0] VAL_5 = 8'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        logic [7:0] v;
        case (code)
            COIN_1:  v = VAL_1;
            COIN_2:  v = VAL_2;
            COIN_5:  v = VAL_5;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Adds in 9 bits so the carry shows an overflow, then clamps to 255.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, stability-count debouncer and
// a single-cycle pulse on each debounced rising edge.
module coin_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic rise
);

    logic       sync_a;
    logic       sync_b;
    logic       deb;
    logic       deb_d;
    logic [7:0] cnt;

    // The level only flips once the synchronised value has disagreed with it
    // for DEB_CYCLES consecutive samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
            cnt    <= 8'd0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            deb_d  <= deb;
            if (sync_b != deb) begin
                if (cnt == 8'(DEB_CYCLES - 1)) begin
                    deb <= sync_b;
                    cnt <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

    assign rise = deb & ~deb_d;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces three coin sensors, queues one pending
// coin per channel and emits them as spaced single-cycle codes with a running total.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       coin1_raw,
    input  logic       coin2_raw,
    input  logic       coin5_raw,
    input  logic       accept_en,
    output logic [1:0] coin_code,
    output logic       coin_valid,
    output logic [7:0] total_cents,
    output logic       err
);

    logic [2:0]   raw_vec;
    logic [2:0]   rise;
    logic [2:0]   pending;
    logic [2:0]   pick;
    logic [2:0]   clear;
    logic [2:0]   accepted;
    logic [1:0]   pick_code;
    logic         err_set;
    sched_state_t state;

    assign raw_vec = {coin5_raw, coin2_raw, coin1_raw};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        coin_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk (clk),
            .rstn(rstn),
            .raw (raw_vec[i]),
            .rise(rise[i])
        );
    end

    always_comb begin
        pick      = 3'b000;
        pick_code = COIN_NONE;
        if (pending[2]) begin
            pick      = 3'b100;
            pick_code = COIN_5;
        end else if (pending[1]) begin
            pick      = 3'b010;
            pick_code = COIN_2;
        end else if (pending[0]) begin
            pick      = 3'b001;
            pick_code = COIN_1;
        end
    end

    // A new accepted rise outranks the scheduler's clear, so a coin arriving
    // just as its predecessor is taken is kept rather than counted as lost.
    assign clear    = (state == IDLE) ? pick : 3'b000;
    assign accepted = rise & {3{accept_en}};
    assign err_set  = (|(rise & ~{3{accept_en}})) | (|(accepted & pending & ~clear));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 3'b000;
            err     <= 1'b0;
        end else begin
            pending <= (pending & ~clear) | accepted;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            coin_code   <= COIN_NONE;
            coin_valid  <= 1'b0;
            total_cents <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        coin_code   <= pick_code;
                        coin_valid  <= 1'b1;
                        total_cents <= sat_add(total_cents, coin_value(pick_code));
                        state       <= EMIT;
                    end else begin
                        coin_code  <= COIN_NONE;
                        coin_valid <= 1'b0;
                    end
                end
                EMIT: begin
                    coin_code  <= COIN_NONE;
                    coin_valid <= 1'b0;
                    state      <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    coin_code  <= COIN_NONE;
                    coin_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios with literal
// expectations plus randomized sensor traffic against a behavioural model.
module tb_coin_acceptor;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       coin1_raw;
    logic       coin2_raw;
    logic       coin5_raw;
    logic       accept_en;
    logic [1:0] coin_code;
    logic       coin_valid;
    logic [7:0] total_cents;
    logic       err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         seen_cyc[$];
    logic [1:0] seen_code[$];

    // Behavioural model state
    int         run[3];
    bit         lvl[3];
    bit         s1[3];
    bit         s2[3];
    bit         rise_f[3];
    bit         pend[3];
    int         cool;
    logic [1:0] m_code;
    int         m_total;
    bit         m_err;
    int         vals[3] = '{1, 2, 5};

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEB_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .coin1_raw  (coin1_raw),
        .coin2_raw  (coin2_raw),
        .coin5_raw  (coin5_raw),
        .accept_en  (accept_en),
        .coin_code  (coin_code),
        .coin_valid (coin_valid),
        .total_cents(total_cents),
        .err        (err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: a coin is a sensor level that stays changed for DEB synchronised
    // samples; the scheduler may emit once every three cycles, highest value first.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_code  = 2'b00;
            m_total = 0;
            m_err   = 1'b0;
            cool    = 0;
            for (int i = 0; i < 3; i++) begin
                run[i]    = 0;
                lvl[i]    = 1'b0;
                s1[i]     = 1'b0;
                s2[i]     = 1'b0;
                rise_f[i] = 1'b0;
                pend[i]   = 1'b0;
            end
        end else begin
            bit cleared[3];
            bit raw_now[3];
            bit found;
            bit pend_old;
            bit nxt_rise;
            raw_now[0] = coin1_raw;
            raw_now[1] = coin2_raw;
            raw_now[2] = coin5_raw;
            found  = 1'b0;
            m_code = 2'b00;
            for (int i = 0; i < 3; i++) cleared[i] = 1'b0;
            if (cool > 0) begin
                cool--;
            end else begin
                for (int p = 2; p >= 0; p--) begin
                    if (!found && pend[p]) begin
                        found      = 1'b1;
                        cleared[p] = 1'b1;
                        m_code     = 2'(p + 1);
                        m_total    = (m_total + vals[p] > 255) ? 255 : m_total + vals[p];
                        cool       = 2;
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                pend_old = pend[i];
                if (cleared[i]) pend[i] = 1'b0;
                if (rise_f[i]) begin
                    if (accept_en) begin
                        if (pend_old && !cleared[i]) m_err = 1'b1;
                        pend[i] = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                nxt_rise = 1'b0;
                if (s2[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        lvl[i]   = s2[i];
                        run[i]   = 0;
                        nxt_rise = lvl[i];
                    end
                end else begin
                    run[i] = 0;
                end
                rise_f[i] = nxt_rise;
                s2[i]     = s1[i];
                s1[i]     = raw_now[i];
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        checkOutput("coin_code", int'(coin_code), int'(m_code));
        checkOutput("coin_valid", int'(coin_valid), int'(m_code != 2'b00));
        checkOutput("total_cents", int'(total_cents), m_total);
        checkOutput("err", int'(err), int'(m_err));
        if (coin_valid) begin
            seen_cyc.push_back(cyc);
            seen_code.push_back(coin_code);
        end
    end

    task automatic applyStimulus(input logic r1, input logic r2, input logic r5,
                                 input logic acc, input int cycles);
        coin1_raw = r1;
        coin2_raw = r2;
        coin5_raw = r5;
        accept_en = acc;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic doReset();
        rstn      = 1'b0;
        coin1_raw = 1'b0;
        coin2_raw = 1'b0;
        coin5_raw = 1'b0;
        accept_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2);
        seen_cyc.delete();
        seen_code.delete();
    endtask

    initial begin
        int c0;
        int dur;

        doReset();
        checkOutput("reset coin_code", int'(coin_code), 0);
        checkOutput("reset coin_valid", int'(coin_valid), 0);
        checkOutput("reset total", int'(total_cents), 0);
        checkOutput("reset err", int'(err), 0);

        // Single clean 1-cent press: code 01 nineteen edges after first sample
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 25);
        checkOutput("t1 code count", seen_code.size(), 1);
        checkOutput("t1 code", seen_code.size() > 0 ? int'(seen_code[0]) : -1, 1);
        checkOutput("t1 latency", seen_cyc.size() > 0 ? seen_cyc[0] - (c0 + 1) : -1, 19);
        checkOutput("t1 total", int'(total_cents), 1);
        checkOutput("t1 err", int'(err), 0);

        // Bouncy 5-cent press
        doReset();
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 25);
        checkOutput("t2 code count", seen_code.size(), 1);
        checkOutput("t2 code", seen_code.size() > 0 ? int'(seen_code[0]) : -1, 3);
        checkOutput("t2 total", int'(total_cents), 5);

        // All three sensors rise together
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 25);
        checkOutput("t3 code count", seen_code.size(), 3);
        if (seen_code.size() == 3) begin
            checkOutput("t3 first", int'(seen_code[0]), 3);
            checkOutput("t3 second", int'(seen_code[1]), 2);
            checkOutput("t3 third", int'(seen_code[2]), 1);
            checkOutput("t3 spacing a", seen_cyc[1] - seen_cyc[0], 3);
            checkOutput("t3 spacing b", seen_cyc[2] - seen_cyc[1], 3);
        end
        checkOutput("t3 total", int'(total_cents), 8);
        checkOutput("t3 err", int'(err), 0);

        // Refused 2-cent coin
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 25);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 30);
        checkOutput("t4 code count", seen_code.size(), 0);
        checkOutput("t4 total", int'(total_cents), 0);
        checkOutput("t4 err sticky", int'(err), 1);

        // Saturation with 52 five-cent coins
        doReset();
        repeat (52) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 20);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 20);
        end
        checkOutput("t5 code count", seen_code.size(), 52);
        checkOutput("t5 total saturated", int'(total_cents), 255);
        checkOutput("t5 err", int'(err), 0);

        // Reset while a coin is pending but not yet emitted
        seen_cyc.delete();
        seen_code.delete();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 19);
        rstn      = 1'b0;
        coin5_raw = 1'b0;
        #1;
        checkOutput("t6 async code", int'(coin_code), 0);
        checkOutput("t6 async valid", int'(coin_valid), 0);
        checkOutput("t6 async total", int'(total_cents), 0);
        checkOutput("t6 async err", int'(err), 0);
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 40);
        checkOutput("t6 no emit", seen_code.size(), 0);
        checkOutput("t6 total", int'(total_cents), 0);

        // Randomized sensor traffic, glitches and refusals
        doReset();
        for (int n = 0; n < 250; n++) begin
            dur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                              : int'($urandom_range(16, 45));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0), dur);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
